csa_pipe_adder: RTL and testbench

- Parametrised, two-stage pipelined carry-select adder/subtractor with valid/ready handshakes on input and output.
- Successor to the fixed 8-bit combinational carry-select adder. Adds generic width and block size, a subtract mode, a signed-overflow flag and back-pressure-aware pipelining.
- Sits between operand producers (register file / ALU operand latches) and result consumers in the CPU datapath. Sustains one operation per clock when unstalled.

---
 rtl/csa_pkg.sv | 27 ++
 rtl/csa_dual_block.sv | 39 +++
 rtl/csa_pipe_adder.sv | 159 +++++++++++++++
 tb/tb_csa_pipe_adder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared constants, block-count helper and stage-1 record type for csa_pipe_adder
//
// Purpose: common definitions for the pipelined carry-select adder.
//   DEFAULT_WIDTH / DEFAULT_BLK : default operand width and block width
//   MAX_BLK                     : widest block the stage-1 record can carry
//   blk_rec_t                   : per-block stage-1 record {sum0, sum1, c0, c1}
//   nblk()                      : number of carry-select blocks for a width/block pair
package csa_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_BLK   = 4;
  localparam int MAX_BLK       = 32;

  // Sums are stored LSB-aligned; bits above the instance's BLK are held at zero.
  typedef struct packed {
    logic [MAX_BLK-1:0] sum0;
    logic [MAX_BLK-1:0] sum1;
    logic               c0;
    logic               c1;
  } blk_rec_t;

  function automatic int nblk(input int width, input int blk);
    if (blk < 1) return 0;
    return width / blk;
  endfunction

endpackage

// File: rtl/csa_dual_block.sv
// rtl/csa_dual_block.sv - BLK-bit combinational dual ripple adder
//
// Purpose: produce both candidate results of one carry-select block.
// Ports:
//   a, b  in  BLK  block operands (b already conditioned for subtract)
//   sum0  out BLK  a+b with carry-in 0
//   c0    out 1    carry-out with carry-in 0
//   sum1  out BLK  a+b with carry-in 1
//   c1    out 1    carry-out with carry-in 1
module csa_dual_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  output logic [BLK-1:0] sum0,
  output logic           c0,
  output logic [BLK-1:0] sum1,
  output logic           c1
);

  logic r0;
  logic r1;

  always_comb begin
    r0   = 1'b0;
    r1   = 1'b1;
    sum0 = '0;
    sum1 = '0;
    for (int i = 0; i < BLK; i++) begin
      sum0[i] = a[i] ^ b[i] ^ r0;
      r0      = (a[i] & b[i]) | (r0 & (a[i] ^ b[i]));
      sum1[i] = a[i] ^ b[i] ^ r1;
      r1      = (a[i] & b[i]) | (r1 & (a[i] ^ b[i]));
    end
    c0 = r0;
    c1 = r1;
  end

endmodule

// File: rtl/csa_pipe_adder.sv
// rtl/csa_pipe_adder.sv - two-stage pipelined carry-select adder/subtractor with valid/ready
//
// Purpose: A+B+cin (sub=0) or A-B-cin (sub=1), one result per clock when unstalled.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake
//   a, b  [WIDTH]       operands
//   cin                 carry-in (add) / borrow-in (sub)
//   sub                 0 = add, 1 = subtract
//   out_valid/out_ready result handshake
//   sum   [WIDTH]       result, modulo 2^WIDTH
//   cout                raw MSB carry-out (borrow-out = ~cout in sub mode)
//   ovf                 two's-complement signed overflow
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BLK   = DEFAULT_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NBLK = nblk(WIDTH, BLK);

  if (BLK < 1) begin : g_bad_blk
    $error("csa_pipe_adder: BLK must be at least 1");
  end else if ((WIDTH % BLK) != 0) begin : g_bad_width
    $error("csa_pipe_adder: WIDTH must be a multiple of BLK");
  end else if (BLK > MAX_BLK) begin : g_bad_max
    $error("csa_pipe_adder: BLK exceeds MAX_BLK");
  end

  // Operand conditioning: subtract is A + ~B + ~cin.
  logic [WIDTH-1:0] beff;
  logic             ceff;
  assign beff = sub ? ~b : b;
  assign ceff = sub ? ~cin : cin;

  // Handshake: stage 2 can load when empty or draining; stage 1 when empty or moving on.
  logic s1_valid;
  logic s2_load;
  logic in_fire;
  assign s2_load  = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_load;
  assign in_fire  = in_valid & in_ready;

  // Stage 1 per-block candidates, flattened for the select chain.
  logic [NBLK-1:0]          s1_c0;
  logic [NBLK-1:0]          s1_c1;
  logic [NBLK-1:0][BLK-1:0] s1_sum0;
  logic [NBLK-1:0][BLK-1:0] s1_sum1;
  logic                     s1_ceff;
  logic                     s1_a_msb;
  logic                     s1_b_msb;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    logic [BLK-1:0] blk_sum0;
    logic [BLK-1:0] blk_sum1;
    logic           blk_c0;
    logic           blk_c1;
    blk_rec_t       rec_d;
    blk_rec_t       rec_q;
    logic           unused_rec;

    csa_dual_block #(.BLK(BLK)) u_dual (
      .a    (a[k*BLK +: BLK]),
      .b    (beff[k*BLK +: BLK]),
      .sum0 (blk_sum0),
      .c0   (blk_c0),
      .sum1 (blk_sum1),
      .c1   (blk_c1)
    );

    always_comb begin
      rec_d                = '0;
      rec_d.sum0[BLK-1:0]  = blk_sum0;
      rec_d.sum1[BLK-1:0]  = blk_sum1;
      rec_d.c0             = blk_c0;
      rec_d.c1             = blk_c1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rec_q <= '0;
      end else if (in_fire) begin
        rec_q <= rec_d;
      end
    end

    assign s1_sum0[k]  = rec_q.sum0[BLK-1:0];
    assign s1_sum1[k]  = rec_q.sum1[BLK-1:0];
    assign s1_c0[k]    = rec_q.c0;
    assign s1_c1[k]    = rec_q.c1;
    // Record bits above BLK are constant zero padding.
    assign unused_rec  = ^{rec_q.sum0, rec_q.sum1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ceff  <= 1'b0;
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
    end else begin
      s1_valid <= in_fire | (s1_valid & ~s2_load);
      if (in_fire) begin
        s1_ceff  <= ceff;
        s1_a_msb <= a[WIDTH-1];
        s1_b_msb <= beff[WIDTH-1];
      end
    end
  end

  // Stage 2 select chain: each block's carry-in picks the next block's candidate.
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             carry;

  always_comb begin
    sum_d = '0;
    carry = s1_ceff;
    for (int k = 0; k < NBLK; k++) begin
      sum_d[k*BLK +: BLK] = carry ? s1_sum1[k] : s1_sum0[k];
      carry               = carry ? s1_c1[k]   : s1_c0[k];
    end
    cout_d = carry;
    ovf_d  = (s1_a_msb == s1_b_msb) & (sum_d[WIDTH-1] != s1_a_msb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= sum_d;
        cout <= cout_d;
        ovf  <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// tb/tb_csa_pipe_adder.sv - self-checking bench for csa_pipe_adder
module tb_csa_pipe_adder;

  localparam int W = 16;
  localparam int NRAND = 10000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  csa_pipe_adder #(.WIDTH(16), .BLK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic; returns {ovf, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
    logic [W-1:0] be;
    logic         ce;
    longint       u;
    longint       s;
    logic [W-1:0] rs;
    logic         rc;
    logic         ro;
    be = msub ? ~mb : mb;
    ce = msub ? ~mcin : mcin;
    u  = longint'(ma) + longint'(be) + longint'(ce);
    s  = longint'($signed(ma)) + longint'($signed(be)) + longint'(ce);
    rs = W'(u);
    rc = u >= (longint'(1) << W);
    ro = (s > ((longint'(1) << (W-1)) - 1)) || (s < -(longint'(1) << (W-1)));
    return {ro, rc, rs};
  endfunction

  // Scoreboard: expected results of accepted, not-yet-delivered bundles.
  logic [W+1:0] expq[$];
  logic [W-1:0] got[$];
  logic         prev_stall = 1'b0;
  logic [W+1:0] prev_out = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (expq.size() < 2) || out_ready});
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          chk("sum",  {16'd0, sum},  {16'd0, expq[0][W-1:0]});
          chk("cout", {31'd0, cout}, {31'd0, expq[0][W]});
          chk("ovf",  {31'd0, ovf},  {31'd0, expq[0][W+1]});
        end
        if (prev_stall)
          chk("hold_stable", {14'd0, ovf, cout, sum}, {14'd0, prev_out});
      end else if (prev_stall) begin
        chk("valid_dropped_in_stall", 32'd0, 32'd1);
      end
      if (in_valid && in_ready)
        expq.push_back(model(a, b, cin, sub));
      if (out_valid && out_ready) begin
        got.push_back(sum);
        if (expq.size() > 0) void'(expq.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {ovf, cout, sum};
    end
  end

  // Single transfer with out_ready=1; checks exact 2-cycle latency and literal results.
  task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tcin, input logic tsub,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    logic [W+1:0] m;
    m = model(ta, tb, tcin, tsub);
    chk({name, "_model"}, {14'd0, m}, {14'd0, eo, ec, es});
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; a = ta; b = tb; cin = tcin; sub = tsub;
    @(negedge clk);
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({name, "_lat2_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_sum"},  {16'd0, sum},  {16'd0, es});
    chk({name, "_cout"}, {31'd0, cout}, {31'd0, ec});
    chk({name, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
  endtask

  initial begin
    int idx;
    int cyc;
    int accepted;
    logic fired;
    logic [W-1:0] exp_stream [5];

    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum",       {16'd0, sum},       32'd0);
    chk("rst_cout",      {31'd0, cout},      32'd0);
    chk("rst_ovf",       {31'd0, ovf},       32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_op("add_carry_ripple", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_op("add_wrap",         16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("add_ovf",          16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("sub_borrow",       16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_ovf",          16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op("add_cin",          16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
    do_op("sub_cin",          16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);

    // Back-to-back stream with the consumer stalled.
    @(posedge clk); #1;
    got.delete();
    out_ready = 1'b0;
    idx = 0;
    cyc = 0;
    while (got.size() < 5 && cyc < 40) begin
      @(posedge clk); #1;
      if (cyc == 6) out_ready = 1'b1;
      in_valid = (idx < 5);
      a = W'(idx + 1);
      b = W'(idx + 1);
      cin = 1'b0;
      sub = 1'b0;
      @(negedge clk);
      if (cyc == 5) begin
        chk("stream_in_ready_full", {31'd0, in_ready}, 32'd0);
        chk("stream_accepted_2",    idx,               32'd2);
        chk("stream_hold_sum",      {16'd0, sum},      32'd2);
      end
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_stream = '{16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h000A};
    chk("stream_count", got.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < got.size()) chk($sformatf("stream_order_%0d", i), {16'd0, got[i]}, {16'd0, exp_stream[i]});

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; a = 16'h0001; b = 16'h0002;
    @(posedge clk); #1;
    a = 16'h0003; b = 16'h0004;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_sum",       {16'd0, sum},       32'd0);
    chk("async_rst_cout",      {31'd0, cout},      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
    end
    do_op("post_rst_op", 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);

    // Random traffic with random back-pressure; offered bundles hold until taken.
    accepted = 0;
    cyc = 0;
    fired = 1'b0;
    in_valid = 1'b0;
    while (accepted < NRAND && cyc < 60000) begin
      @(posedge clk); #1;
      if (!in_valid || fired) begin
        in_valid = ($urandom % 4) != 0;
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
      end
      out_ready = ($urandom % 4) != 0;
      @(negedge clk);
      fired = in_valid && in_ready;
      if (fired) accepted++;
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rand_accepted", accepted, NRAND);
    cyc = 0;
    while (expq.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rand_drained", expq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
